// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES datapath constants and the default key-mix beat record.
// No ports; imported by key_mix_pipe.
// -----------------------------------------------------------------------------
package des_pkg;

    localparam int DES_BLOCK_W = 64;
    localparam int DES_EXP_W   = 48;
    localparam int DES_ROUNDS  = 16;
    localparam int DES_TAG_W   = $clog2(DES_ROUNDS);

    // Beat record at native DES widths. The pipeline builds its own
    // parameter-sized copy of this layout from its WIDTH/TAG_W localparams.
    typedef struct packed {
        logic [DES_EXP_W-1:0] data;
        logic [DES_TAG_W-1:0] tag;
        logic                 bypassed;
    } mix_beat_t;

endpackage

// File: rtl/key_mix_reg.sv
// -----------------------------------------------------------------------------
// key_mix_reg
// One valid/ready register slice of the key-mix pipeline.
//   i_valid / o_ready / i_data : upstream side (o_ready = slice loads this cycle)
//   o_valid / i_ready / o_data : downstream side
// The slice loads whenever it is empty or its beat is being taken, so bubbles
// collapse even while the far end is stalled.
// -----------------------------------------------------------------------------
module key_mix_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_load;

    assign w_load  = ~r_valid | i_ready;
    assign o_ready = w_load;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= i_valid;
            // Payload of an empty slice is left untouched; only valid matters.
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/key_mix_pipe.sv
// -----------------------------------------------------------------------------
// key_mix_pipe
// DES key-mixing stage: result = in_bypass ? in_data : in_data ^ in_key,
// carried with its round tag through DEPTH valid/ready register slices.
//   in_valid/in_ready/in_data/in_key/in_tag/in_bypass : upstream beat
//   out_valid/out_ready/out_data/out_tag/out_bypassed : downstream beat
//   beat_count  : saturating count of delivered beats
//   clear_count : synchronous clear of beat_count (wins over an increment)
// -----------------------------------------------------------------------------
module key_mix_pipe
    import des_pkg::*;
#(
    parameter int WIDTH = DES_EXP_W,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_key,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_bypass,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_bypassed,
    output logic [CNT_W-1:0] beat_count,
    input  logic             clear_count
);

    localparam int               BEAT_W  = WIDTH + TAG_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             bypassed;
    } beat_t;

    // Index k is the input side of slice k; index DEPTH is the output port.
    beat_t          w_beat [DEPTH+1];
    logic [DEPTH:0] w_vld;
    logic [DEPTH:0] w_rdy;
    logic           w_xfer;
    logic [CNT_W-1:0] r_count;

    assign w_beat[0].data     = in_bypass ? in_data : (in_data ^ in_key);
    assign w_beat[0].tag      = in_tag;
    assign w_beat[0].bypassed = in_bypass;
    assign w_vld[0]           = in_valid;
    assign w_rdy[DEPTH]       = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        key_mix_reg #(
            .W (BEAT_W)
        ) u_reg (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_vld[k]),
            .o_ready (w_rdy[k]),
            .i_data  (w_beat[k]),
            .o_valid (w_vld[k+1]),
            .i_ready (w_rdy[k+1]),
            .o_data  (w_beat[k+1])
        );
    end

    assign in_ready     = w_rdy[0];
    assign out_valid    = w_vld[DEPTH];
    assign out_data     = w_beat[DEPTH].data;
    assign out_tag      = w_beat[DEPTH].tag;
    assign out_bypassed = w_beat[DEPTH].bypassed;

    assign w_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear_count) begin
            r_count <= '0;
        end else if (w_xfer && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign beat_count = r_count;

endmodule

// File: tb/tb_key_mix_pipe.sv
module tb_key_mix_pipe;

    localparam int WIDTH = 48;
    localparam int DEPTH = 2;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready, in_ready4;
    logic [WIDTH-1:0] in_data = '0;
    logic [WIDTH-1:0] in_key = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_bypass = 1'b0;
    logic             out_valid, out_valid4;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data, out_data4;
    logic [TAG_W-1:0] out_tag, out_tag4;
    logic             out_bypassed, out_bypassed4;
    logic [15:0]      beat_count;
    logic [3:0]       beat_count4;
    logic             clear_count = 1'b0;

    always #5 clk = ~clk;

    key_mix_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .in_tag(in_tag), .in_bypass(in_bypass),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_bypassed(out_bypassed), .beat_count(beat_count),
        .clear_count(clear_count));

    key_mix_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_key(in_key), .in_tag(in_tag), .in_bypass(in_bypass),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_tag(out_tag4), .out_bypassed(out_bypassed4), .beat_count(beat_count4),
        .clear_count(clear_count));

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] k;
        logic [TAG_W-1:0] tag;
        logic             byp;
        logic [WIDTH-1:0] exp;
    } vec_t;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [TAG_W-1:0] tag;
        logic             byp;
    } beat_t;

    beat_t q[$];
    int    vecs = 0;
    int    errs = 0;
    int    m16 = 0, m4 = 0;
    int    cyc = 0, n_out = 0, t_first = -1, t_last = -1;
    logic  hold_pend = 1'b0;
    beat_t hold_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each accepted beat becomes one expected output, in order.
    always @(negedge clk) begin
        beat_t e;
        beat_t cur;
        if (!rst_n) begin
            q.delete();
            m16 = 0;
            m4 = 0;
            hold_pend = 1'b0;
        end else begin
            cyc++;
            chk("beat_count", 64'(beat_count), 64'(m16));
            chk("beat_count_cnt4", 64'(beat_count4), 64'(m4));
            cur = '{d: out_data, tag: out_tag, byp: out_bypassed};
            if (hold_pend) begin
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_hold", 64'(cur), 64'(hold_val));
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = cur;
            if (out_valid && out_ready) begin
                n_out++;
                if (t_first < 0) t_first = cyc;
                t_last = cyc;
                if (q.size() == 0) begin
                    chk("unexpected_beat", 64'(out_tag), 64'hDEAD);
                end else begin
                    e = q.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.d));
                    chk("out_tag", 64'(out_tag), 64'(e.tag));
                    chk("out_bypassed", 64'(out_bypassed), 64'(e.byp));
                    chk("cnt4_out_valid", 64'(out_valid4), 64'(1));
                    chk("cnt4_out_data", 64'(out_data4), 64'(e.d));
                    chk("cnt4_out_tag", 64'(out_tag4), 64'(e.tag));
                    chk("cnt4_out_byp", 64'(out_bypassed4), 64'(e.byp));
                end
            end
            if (in_valid && in_ready)
                q.push_back('{d: in_bypass ? in_data : (in_data ^ in_key),
                              tag: in_tag, byp: in_bypass});
            if (clear_count) begin
                m16 = 0;
                m4 = 0;
            end else if (out_valid && out_ready) begin
                if (m16 < 65535) m16++;
                if (m4 < 15) m4++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] k,
                         input logic [TAG_W-1:0] t, input logic b);
        in_valid  = 1'b1;
        in_data   = d;
        in_key    = k;
        in_tag    = t;
        in_bypass = b;
    endtask

    function automatic logic [WIDTH-1:0] rnd48();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   n0, acc;
        logic [WIDTH-1:0] held;

        tbl[0] = '{48'hFFFF_0000_AAAA, 48'h0F0F_0F0F_0F0F, 4'd3, 1'b0, 48'hF0F0_0F0F_A5A5};
        tbl[1] = '{48'hFFFF_0000_AAAA, 48'h0F0F_0F0F_0F0F, 4'd3, 1'b1, 48'hFFFF_0000_AAAA};
        tbl[2] = '{48'h0000_0000_0000, 48'hFFFF_FFFF_FFFF, 4'd0, 1'b0, 48'hFFFF_FFFF_FFFF};
        tbl[3] = '{48'h1234_5678_9ABC, 48'h1234_5678_9ABC, 4'd15, 1'b0, 48'h0000_0000_0000};
        tbl[4] = '{48'h8000_0000_0001, 48'hFFFF_FFFF_FFFF, 4'd9, 1'b1, 48'h8000_0000_0001};
        tbl[5] = '{48'hC3C3_C3C3_C3C3, 48'h5A5A_5A5A_5A5A, 4'd6, 1'b0, 48'h9999_9999_9999};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        chk("rst_out_byp", 64'(out_bypassed), 64'(0));
        chk("rst_beat_count", 64'(beat_count), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        tick();

        // Single beats: check value and exact DEPTH-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].d, tbl[i].k, tbl[i].tag, tbl[i].byp);
            tick();
            in_valid = 1'b0;
            for (int c = 1; c < DEPTH; c++) begin
                chk("lat_early", 64'(out_valid), 64'(0));
                tick();
            end
            chk("lat_valid", 64'(out_valid), 64'(1));
            chk("vec_data", 64'(out_data), 64'(tbl[i].exp));
            chk("vec_tag", 64'(out_tag), 64'(tbl[i].tag));
            chk("vec_byp", 64'(out_bypassed), 64'(tbl[i].byp));
            tick();
        end

        // Back-to-back stream of 16 tagged beats.
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        chk("clear_idle", 64'(beat_count), 64'(0));
        n0 = n_out;
        t_first = -1;
        for (int i = 0; i < 16; i++) begin
            drive(rnd48(), rnd48(), TAG_W'(i), 1'($urandom_range(0, 1)));
            chk("stream_in_ready", 64'(in_ready), 64'(1));
            tick();
        end
        in_valid = 1'b0;
        repeat (DEPTH + 2) tick();
        chk("stream_count", 64'(n_out - n0), 64'(16));
        chk("stream_rate", 64'(t_last - t_first), 64'(15));
        chk("stream_beat_count", 64'(beat_count), 64'(16));
        chk("stream_sat_cnt4", 64'(beat_count4), 64'(15));

        for (int i = 0; i < 4; i++) begin
            drive(rnd48(), rnd48(), TAG_W'(i), 1'b0);
            tick();
        end
        in_valid = 1'b0;
        repeat (DEPTH + 2) tick();
        chk("twenty_beat_count", 64'(beat_count), 64'(20));
        chk("twenty_sat_cnt4", 64'(beat_count4), 64'(15));

        // Stall: in_ready falls after DEPTH accepts, output holds.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            drive(rnd48(), rnd48(), TAG_W'(i + 4), 1'($urandom_range(0, 1)));
            if (!in_ready) break;
            acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("stall_accepts", 64'(acc), 64'(DEPTH));
        chk("stall_in_ready_cnt4", 64'(in_ready4), 64'(0));
        held = out_data;
        repeat (3) tick();
        chk("stall_data_held", 64'(out_data), 64'(held));
        out_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        chk("stall_drained", 64'(q.size()), 64'(0));
        chk("stall_out_idle", 64'(out_valid), 64'(0));

        // Clear coinciding with a delivery: clear wins.
        out_ready = 1'b0;
        drive(48'h0123_4567_89AB, 48'h0, 4'd7, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (DEPTH) tick();
        chk("clr_pending_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        chk("clr_xfer_count", 64'(beat_count), 64'(0));
        chk("clr_xfer_cnt4", 64'(beat_count4), 64'(0));
        chk("clr_xfer_gone", 64'(out_valid), 64'(0));

        // Reset with two beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(rnd48(), rnd48(), TAG_W'(10 + i), 1'b0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'(0));
        chk("async_rst_valid4", 64'(out_valid4), 64'(0));
        chk("async_rst_count", 64'(beat_count), 64'(0));
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_no_stale", 64'(out_valid), 64'(0));
        end

        // Randomised traffic with random backpressure and clears.
        for (int i = 0; i < 600; i++) begin
            drive(rnd48(), rnd48(), TAG_W'($urandom()), 1'($urandom_range(0, 1)));
            in_valid    = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            clear_count = ($urandom_range(0, 22) == 0);
            tick();
        end
        in_valid = 1'b0;
        clear_count = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        chk("rand_drained", 64'(q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/key_mix_pipe.md
Name: key_mix_pipe

Overview:
Parametrised, pipelined key-mixing stage for the DES datapath. It XORs an expanded data word with a round key, and can optionally pass the data through unmixed. Each beat carries a round tag alongside the data. The block sits between the expansion permutation and the S-box stage, and provides valid/ready flow control so the round pipeline can stall without losing beats.

Parameters:
- WIDTH, 48, data/key width in bits (≥1).
- DEPTH, 2, number of register stages (≥1); unstalled latency in cycles.
- TAG_W, 4, round-tag width carried with each beat.
- CNT_W, 16, width of the saturating beat counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  WIDTH  expanded data bits.
- in_key  in  WIDTH  round key.
- in_tag  in  TAG_W  round index travelling with the beat.
- in_bypass  in  1  1 = output in_data unmodified; 0 = data XOR key.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  mixed (or bypassed) result.
- out_tag  out  TAG_W  tag of the output beat.
- out_bypassed  out  1  bypass flag of the output beat.
- beat_count  out  CNT_W  beats delivered (out_valid & out_ready), saturating.
- clear_count  in  1  synchronous clear of beat_count.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits clear; out_valid = 0; out_data = 0; out_tag = 0; out_bypassed = 0; beat_count = 0.
  - in_ready = 1 once reset deasserts.
- Mix function is computed at the first stage: result = in_bypass ? in_data : (in_data ^ in_key). Later stages only carry the result.
- Pipeline: DEPTH stages, each holding {valid, data, tag, bypassed}. Stage k = 0 is the input stage; stage DEPTH-1 drives the out_* ports.
- Stage advance: stage k loads from stage k-1 (or from the input for k = 0) when stage k is empty or stage k+1 is taking its beat. The last stage advances when empty or when out_ready is high.
- in_ready = (stage 0 empty) OR (stage 0 advancing this cycle). It is combinational from the downstream ready chain; the block adds no combinational path from in_valid to in_ready.
- Bubbles collapse: a beat moves into any empty downstream stage even while the output is stalled.
- Latency: a beat accepted in cycle N appears with out_valid = 1 in cycle N+DEPTH when there is no stall. Throughput is 1 beat/cycle with out_ready held high.
- Stall: while out_valid = 1 and out_ready = 0, out_data, out_tag and out_bypassed hold stable. After DEPTH beats are in flight, in_ready drops to 0.
- Transfer rules:
  - Input transfer occurs only when in_valid & in_ready.
  - Output transfer occurs only when out_valid & out_ready.
  - No beat is dropped or duplicated; order is preserved.
- Data registers of invalid stages hold their last value; only valid bits are significant.
- beat_count:
  - increments by 1 on each output transfer and saturates at 2^CNT_W-1 (no wrap).
  - clear_count sets it to 0 next cycle.
  - If clear_count and a transfer occur in the same cycle, the result is 0 (clear wins).
- Mid-operation reset: all in-flight beats are discarded; out_valid falls asynchronously.
- Width rules: in_data, in_key and the result are all WIDTH bits; there is no sign or carry.

Decomposition:
- Package des_pkg: DES_BLOCK_W = 64, DES_EXP_W = 48, DES_ROUNDS = 16, and a typedef mix_beat_t struct {data, tag, bypassed} parametrised through localparams in the top.
- One sub-module, key_mix_reg: a single valid/ready register slice. It is instantiated DEPTH times via a generate loop; the top adds the mix logic and the counter.

Test Plan:
1. Reset, then in_data = 48'hFFFF_0000_AAAA, in_key = 48'h0F0F_0F0F_0F0F, bypass = 0, tag = 3, out_ready = 1 → out_data = 48'hF0F0_0F0F_A5A5 with out_tag = 3, exactly DEPTH cycles later.
2. Same data with in_bypass = 1 → out_data = 48'hFFFF_0000_AAAA and out_bypassed = 1.
3. Stream 16 beats with tags 0..15 back-to-back, out_ready = 1 → 16 consecutive outputs in order, 1 beat/cycle, beat_count = 16.
4. out_ready = 0 while streaming → in_ready drops after DEPTH accepts and out_data holds stable. Release out_ready → all beats delivered, none lost or duplicated.
5. With CNT_W = 4, deliver 20 beats → beat_count saturates at 15. Assert clear_count during a transfer → beat_count = 0.
6. Assert rst_n low with 2 beats in flight → out_valid = 0 immediately, and no stale beats emerge after reset.
